// File: rtl/sweep_pkg.sv
// Shared constants and state encoding for the triangle sweep controller.
package sweep_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CYCW  = 8;

  // Legacy state codes, kept so existing decode/debug tooling still matches.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    UP   = ST_UP,
    DOWN = ST_DOWN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/sweep_ctrl_updown_core.sv
// Loadable up/down counter: load wins over enable, enable low holds.
module updown_core
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             u_d,
  output logic [WIDTH-1:0] count
);

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= data;
    end else if (en) begin
      if (u_d) begin
        count <= count + 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep sequencer: drives updown_core between latched lo/hi bounds
// for a programmed number of periods, with stop/abort and status reporting.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CYCW  = DEF_CYCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYCW-1:0]  cycles,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYCW-1:0]  cyc_done
);

  state_t           state;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [CYCW-1:0]  cyc_q;

  logic             start_ok;
  logic             at_top;
  logic             at_bot;
  logic [CYCW-1:0]  cyc_next;
  logic             last_period;
  logic             core_load;
  logic             core_en;
  logic             core_ud;

  // Turn-around detection and datapath control, all from current state.
  always_comb begin
    start_ok    = start && (lo < hi);
    at_top      = (count == hi_q - 1'b1);
    at_bot      = (count == lo_q + 1'b1);
    cyc_next    = cyc_done + 1'b1;
    last_period = (cyc_q != '0) && (cyc_next == cyc_q);
    core_load   = (state == IDLE) && start_ok;
    core_en     = ((state == UP) || (state == DOWN)) && !stop;
    core_ud     = (state == UP);
  end

  updown_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (core_load),
    .data  (lo),
    .en    (core_en),
    .u_d   (core_ud),
    .count (count)
  );

  // Sequencer state, config latches and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cyc_q    <= '0;
      dir      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cyc_done <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              lo_q     <= lo;
              hi_q     <= hi;
              cyc_q    <= cycles;
              cyc_done <= '0;
              dir      <= 1'b1;
              busy     <= 1'b1;
              state    <= UP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        UP: begin
          if (stop) begin
            busy  <= 1'b0;
            dir   <= 1'b0;
            state <= IDLE;
          end else if (at_top) begin
            dir   <= 1'b0;
            state <= DOWN;
          end
        end
        DOWN: begin
          if (stop) begin
            busy  <= 1'b0;
            dir   <= 1'b0;
            state <= IDLE;
          end else if (at_bot) begin
            cyc_done <= cyc_next;
            if (last_period) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dir   <= 1'b1;
              state <= UP;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: stimulus pushes per-cycle expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] cycles;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] cyc_done;

  typedef struct {
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  sweep_ctrl #(
    .WIDTH(8),
    .CYCW (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .lo       (lo),
    .hi       (hi),
    .cycles   (cycles),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cyc_done (cyc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form triangle value k cycles after the start edge.
  function automatic logic [7:0] tri_cnt(input int l, input int h, input int k);
    int d;
    int p;
    d = h - l;
    p = k % (2 * d);
    if (p <= d) return 8'(l + p);
    else        return 8'(l + 2 * d - p);
  endfunction

  // Push the outputs expected after the next rising edge, then advance.
  task automatic tick(input string nm, input logic [7:0] c, input logic d,
                      input logic b, input logic dn, input logic e,
                      input logic [7:0] cy);
    exp_t x;
    x.count = c;
    x.dir   = d;
    x.busy  = b;
    x.done  = dn;
    x.err   = e;
    x.cyc   = cy;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic follow(input string nm, input int l, input int h,
                        input int k0, input int k1, input int base);
    for (int k = k0; k <= k1; k++) begin
      int d;
      int p;
      d = h - l;
      p = k % (2 * d);
      tick(nm, tri_cnt(l, h, k), (p < d), 1'b1, 1'b0, 1'b0,
           8'((base + k / (2 * d)) % 256));
    end
  endtask

  // DONE cycle then return to IDLE; optionally poke start/stop during DONE.
  task automatic finish_run(input string nm, input int l, input int n,
                            input bit poke);
    tick(nm, 8'(l), 1'b0, 1'b0, 1'b1, 1'b0, 8'(n));
    if (poke) begin
      start = 1'b1;
      stop  = 1'b1;
    end
    tick({nm, "_idle"}, 8'(l), 1'b0, 1'b0, 1'b0, 1'b0, 8'(n));
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Monitor: compare one expectation per cycle, just after the rising edge.
  initial begin
    checks = 0;
    errors = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t  x;
        string nm;
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (count !== x.count || dir !== x.dir || busy !== x.busy ||
            done !== x.done || err !== x.err || cyc_done !== x.cyc) begin
          errors++;
          $display("FAIL %s t=%0t: got count=%0d dir=%0b busy=%0b done=%0b err=%0b cyc=%0d, want count=%0d dir=%0b busy=%0b done=%0b err=%0b cyc=%0d",
                   nm, $time, count, dir, busy, done, err, cyc_done,
                   x.count, x.dir, x.busy, x.done, x.err, x.cyc);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    lo     = 8'd0;
    hi     = 8'd0;
    cycles = 8'd0;
    tick("reset", 8'd0, 0, 0, 0, 0, 8'd0);
    tick("reset", 8'd0, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;
    tick("idle", 8'd0, 0, 0, 0, 0, 8'd0);

    // Full-range sweep, two periods, no wrap at 255.
    lo = 8'd0; hi = 8'd255; cycles = 8'd2; start = 1'b1;
    follow("full", 0, 255, 0, 0, 0);
    start = 1'b0;
    follow("full", 0, 255, 1, 1019, 0);
    finish_run("full_end", 0, 2, 1'b0);

    // Small sweep 3..5 once; start/stop poked while in DONE.
    lo = 8'd3; hi = 8'd5; cycles = 8'd1; start = 1'b1;
    follow("small", 3, 5, 0, 0, 0);
    start = 1'b0;
    follow("small", 3, 5, 1, 3, 0);
    finish_run("small_end", 3, 1, 1'b1);

    // Rejected starts: equal and inverted bounds.
    lo = 8'd7; hi = 8'd7; start = 1'b1;
    tick("err_eq", 8'd3, 0, 0, 0, 1, 8'd1);
    start = 1'b0;
    tick("err_eq_clr", 8'd3, 0, 0, 0, 0, 8'd1);
    lo = 8'd9; hi = 8'd2; start = 1'b1;
    tick("err_inv", 8'd3, 0, 0, 0, 1, 8'd1);
    start = 1'b0;
    tick("err_inv_clr", 8'd3, 0, 0, 0, 0, 8'd1);
    stop = 1'b1;
    tick("stop_idle", 8'd3, 0, 0, 0, 0, 8'd1);
    stop = 1'b0;

    // Minimum sweep hi = lo + 1 at the top of the range.
    lo = 8'd254; hi = 8'd255; cycles = 8'd2; start = 1'b1;
    follow("min", 254, 255, 0, 0, 0);
    start = 1'b0;
    follow("min", 254, 255, 1, 3, 0);
    finish_run("min_end", 254, 2, 1'b0);

    // Infinite mode; config changes and a start pulse mid-run are ignored.
    lo = 8'd10; hi = 8'd12; cycles = 8'd0; start = 1'b1;
    follow("inf", 10, 12, 0, 0, 0);
    start = 1'b0;
    follow("inf", 10, 12, 1, 4, 0);
    lo = 8'd0; hi = 8'd200; cycles = 8'd1; start = 1'b1;
    follow("inf_cfgchg", 10, 12, 5, 6, 0);
    start = 1'b0;
    follow("inf", 10, 12, 7, 81, 0);
    stop = 1'b1;
    tick("inf_stop", 8'd11, 0, 0, 0, 0, 8'd20);
    stop = 1'b0;
    tick("inf_stop_idle", 8'd11, 0, 0, 0, 0, 8'd20);

    // Stop on the turn-around cycle beats the UP->DOWN transition.
    lo = 8'd20; hi = 8'd30; cycles = 8'd0; start = 1'b1;
    follow("top", 20, 30, 0, 0, 0);
    start = 1'b0;
    follow("top", 20, 30, 1, 9, 0);
    stop = 1'b1;
    tick("stop_top", 8'd29, 0, 0, 0, 0, 8'd0);
    stop = 1'b0;
    tick("stop_top_idle", 8'd29, 0, 0, 0, 0, 8'd0);

    // start and stop together in IDLE, then reset mid-DOWN at count 4.
    lo = 8'd3; hi = 8'd5; cycles = 8'd1; start = 1'b1; stop = 1'b1;
    follow("both", 3, 5, 0, 0, 0);
    start = 1'b0; stop = 1'b0;
    follow("both", 3, 5, 1, 3, 0);
    rst = 1'b1;
    tick("rst_mid", 8'd0, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;
    tick("rst_idle", 8'd0, 0, 0, 0, 0, 8'd0);
    start = 1'b1;
    follow("fresh", 3, 5, 0, 0, 0);
    start = 1'b0;
    follow("fresh", 3, 5, 1, 3, 0);
    finish_run("fresh_end", 3, 1, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
